// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: memory-wait freeze with
// watchdog, mispredict redirect flush window, load-use interlock, stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT      = 64,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [4:0]  c_rs1,
  input  logic [4:0]  c_rs2,
  input  logic        c_use_rs1,
  input  logic        c_use_rs2,
  input  logic [4:0]  e_rd,
  input  logic        e_is_load,
  input  logic        fail_predict,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_f,
  output logic        stall_c,
  output logic        stall_e,
  output logic        stall_m,
  output logic        bubble_e,
  output logic        flush_c,
  output logic        flush_e,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);
  localparam int             WW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]  TMO = WW'(MEM_TIMEOUT);
  localparam logic [3:0]     RB  = 4'(REDIRECT_BUBBLES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [3:0]    fl_cnt;
  logic [WW-1:0] wait_cnt;

  logic mem_wait, mem_to, mem_stall, fp_take, lu_haz, lu_stall;

  always_comb begin
    mem_wait  = mem_req & ~mem_ready;
    mem_to    = mem_wait & (wait_cnt == TMO);
    mem_stall = mem_wait & (wait_cnt < TMO);
    fp_take   = fail_predict & ~mem_stall;
    lu_haz    = e_is_load & (e_rd != 5'd0) &
                ((c_use_rs1 & (c_rs1 == e_rd)) | (c_use_rs2 & (c_rs2 == e_rd)));
    // The watchdog cycle must let everything advance, so it also masks load-use.
    lu_stall  = lu_haz & (state == RUN) & ~mem_stall & ~fail_predict & ~mem_to;
  end

  // Outputs are forced low while reset is asserted, independent of the inputs.
  always_comb begin
    stall_f  = NRST & (mem_stall | lu_stall);
    stall_c  = NRST & (mem_stall | lu_stall);
    stall_e  = NRST & mem_stall;
    stall_m  = NRST & mem_stall;
    bubble_e = NRST & lu_stall;
    flush_c  = NRST & ((state == FLUSH) | fp_take);
    flush_e  = NRST & fp_take;
    mem_err  = NRST & mem_to;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state  <= RUN;
      fl_cnt <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (fp_take && RB != 4'd0) begin
            state  <= FLUSH;
            fl_cnt <= RB;
          end
        end
        FLUSH: begin
          if (!mem_stall) begin
            if (fail_predict) begin
              fl_cnt <= RB;
            end else begin
              fl_cnt <= fl_cnt - 4'd1;
              if (fl_cnt == 4'd1) state <= RUN;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)                  wait_cnt <= '0;
    else if (mem_wait && !mem_to) wait_cnt <= wait_cnt + WW'(1);
    else                        wait_cnt <= '0;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)                                   stall_cycles <= 32'd0;
    else if (stall_f && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
  end
endmodule
